// File: rtl/csa_pkg.sv
// csa_pkg: shared widths and word type for the carry-select adder
package csa_pkg;
    localparam int CSA_WIDTH = 8;
    localparam int CSA_BLOCK = 4;
    typedef logic [CSA_WIDTH-1:0] csa_word_t;
endpackage

// File: rtl/rca_4_bit.sv
// rca_4_bit: 4-bit ripple-carry adder with block propagate
module rca_4_bit
    import csa_pkg::*;
(
    input  logic [CSA_BLOCK-1:0] a,
    input  logic [CSA_BLOCK-1:0] b,
    input  logic                 c_in,
    output logic [CSA_BLOCK-1:0] sum,
    output logic                 c_out,
    output logic                 p
);
    logic [CSA_BLOCK:0] w_c;
    assign w_c[0] = c_in;
    for (genvar i = 0; i < CSA_BLOCK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    assign c_out = w_c[CSA_BLOCK];
    assign p     = &(a ^ b);
endmodule

// File: rtl/csa_8_bit.sv
// csa_8_bit: 8-bit carry-select adder, one registered pipeline stage
module csa_8_bit
    import csa_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  csa_word_t a,
    input  csa_word_t b,
    input  logic      c_in,
    output csa_word_t sum,
    output logic      c_out,
    output logic      p
);
    logic [CSA_BLOCK-1:0] w_s_lo, w_s0, w_s1;
    logic                 w_c4, w_co0, w_co1, w_p_lo, w_p_hi0, w_p_hi1;
    rca_4_bit u_lo (
        .a(a[CSA_BLOCK-1:0]), .b(b[CSA_BLOCK-1:0]), .c_in(c_in),
        .sum(w_s_lo), .c_out(w_c4), .p(w_p_lo)
    );
    rca_4_bit u_hi0 (
        .a(a[CSA_WIDTH-1:CSA_BLOCK]), .b(b[CSA_WIDTH-1:CSA_BLOCK]), .c_in(1'b0),
        .sum(w_s0), .c_out(w_co0), .p(w_p_hi0)
    );
    rca_4_bit u_hi1 (
        .a(a[CSA_WIDTH-1:CSA_BLOCK]), .b(b[CSA_WIDTH-1:CSA_BLOCK]), .c_in(1'b1),
        .sum(w_s1), .c_out(w_co1), .p(w_p_hi1)
    );
    // both high blocks see identical operands, so their propagates agree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            c_out <= 1'b0;
            p     <= 1'b0;
        end else begin
            sum   <= {w_c4 ? w_s1 : w_s0, w_s_lo};
            c_out <= w_c4 ? w_co1 : w_co0;
            p     <= w_p_lo & w_p_hi0 & w_p_hi1;
        end
    end
endmodule

// File: tb/tb_csa_8_bit.sv
// tb_csa_8_bit: directed and random checks of csa_8_bit against an arithmetic model
module tb_csa_8_bit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = 8'hFF, b = 8'h01;
    logic       c_in = 1'b1;
    logic [7:0] sum;
    logic       c_out, p;
    int         n_cmp = 0, n_err = 0;

    csa_8_bit dut (.clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out), .p(p));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        int total;
        @(negedge clk);
        a = ta; b = tb; c_in = tc;
        total = int'(ta) + int'(tb) + int'(tc);
        @(posedge clk);
        #1;
        check({tag, ".sum"}, 32'(sum), 32'(total % 256));
        check({tag, ".cout"}, 32'(c_out), 32'(total / 256));
        check({tag, ".p"}, 32'(p), 32'((ta ^ tb) == 8'hFF));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst.sum", 32'(sum), 32'h00);
        check("rst.cout", 32'(c_out), 32'h0);
        check("rst.p", 32'(p), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply("prop0", 8'hFF, 8'h00, 1'b0);
        apply("prop1", 8'hFF, 8'h00, 1'b1);
        apply("select", 8'h0F, 8'h01, 1'b0);
        apply("maxc", 8'hFF, 8'hFF, 1'b1);
        apply("pipe0", 8'h01, 8'h02, 1'b0);
        apply("pipe1", 8'h80, 8'h80, 1'b0);
        apply("pipe2", 8'h7F, 8'h00, 1'b1);
        apply("pre_ar", 8'hFF, 8'hFF, 1'b1);
        #2;
        a = 8'hFF; b = 8'h01; c_in = 1'b1;
        rst = 1'b1;
        #1;
        check("arst.sum", 32'(sum), 32'h00);
        check("arst.cout", 32'(c_out), 32'h0);
        check("arst.p", 32'(p), 32'h0);
        @(posedge clk);
        #1;
        check("arst_hold.sum", 32'(sum), 32'h00);
        check("arst_hold.p", 32'(p), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst", 8'h12, 8'h34, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? ~ra : 8'($urandom);
            apply("rand", ra, rb, 1'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
